// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: decodes a dot/dash/gap symbol stream to ASCII and queues it in a FIFO.
// Define MORSE_PUNCT_EN to also decode ITU punctuation; otherwise those patterns decode to UNKNOWN_CHAR.
module morse_stream_decoder #(
    parameter int          DEPTH        = 8,
    parameter int          MAX_SYMS     = 6,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sym_valid,
    input  logic [1:0]                 sym_code,
    output logic                       sym_ready,
    input  logic                       clear,
    input  logic                       flush,
    output logic                       char_valid,
    output logic [7:0]                 char_data,
    input  logic                       char_ready,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       seq_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [3:0] MAXC = 4'(MAX_SYMS);

    typedef enum logic [1:0] {COLLECT, EMIT_CHAR, EMIT_SPACE} state_t;

    state_t                state, state_nxt;
    logic [3:0]            sym_cnt;
    logic [MAX_SYMS-1:0]   pattern;
    logic                  bad, pending_space, last_was_space;
    logic [7:0]            mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  accept, gap, pop, room, advance, push;
    logic [7:0]            push_data, char_code;

    // Reorders the LSB-first pattern so the first symbol is the leftmost bit of each table key.
    function automatic logic [7:0] lookup(input logic [3:0] cnt, input logic [MAX_SYMS-1:0] pat);
        logic [7:0] arr;
        arr = '0;
        for (int i = 0; i < MAX_SYMS; i++)
            if (i < int'(cnt)) arr = {arr[6:0], pat[i]};
        case ({cnt, arr})
            {4'd2, 8'b01}:    lookup = "A";
            {4'd4, 8'b1000}:  lookup = "B";
            {4'd4, 8'b1010}:  lookup = "C";
            {4'd3, 8'b100}:   lookup = "D";
            {4'd1, 8'b0}:     lookup = "E";
            {4'd4, 8'b0010}:  lookup = "F";
            {4'd3, 8'b110}:   lookup = "G";
            {4'd4, 8'b0000}:  lookup = "H";
            {4'd2, 8'b00}:    lookup = "I";
            {4'd4, 8'b0111}:  lookup = "J";
            {4'd3, 8'b101}:   lookup = "K";
            {4'd4, 8'b0100}:  lookup = "L";
            {4'd2, 8'b11}:    lookup = "M";
            {4'd2, 8'b10}:    lookup = "N";
            {4'd3, 8'b111}:   lookup = "O";
            {4'd4, 8'b0110}:  lookup = "P";
            {4'd4, 8'b1101}:  lookup = "Q";
            {4'd3, 8'b010}:   lookup = "R";
            {4'd3, 8'b000}:   lookup = "S";
            {4'd1, 8'b1}:     lookup = "T";
            {4'd3, 8'b001}:   lookup = "U";
            {4'd4, 8'b0001}:  lookup = "V";
            {4'd3, 8'b011}:   lookup = "W";
            {4'd4, 8'b1001}:  lookup = "X";
            {4'd4, 8'b1011}:  lookup = "Y";
            {4'd4, 8'b1100}:  lookup = "Z";
            {4'd5, 8'b11111}: lookup = "0";
            {4'd5, 8'b01111}: lookup = "1";
            {4'd5, 8'b00111}: lookup = "2";
            {4'd5, 8'b00011}: lookup = "3";
            {4'd5, 8'b00001}: lookup = "4";
            {4'd5, 8'b00000}: lookup = "5";
            {4'd5, 8'b10000}: lookup = "6";
            {4'd5, 8'b11000}: lookup = "7";
            {4'd5, 8'b11100}: lookup = "8";
            {4'd5, 8'b11110}: lookup = "9";
`ifdef MORSE_PUNCT_EN
            {4'd6, 8'b010101}:  lookup = ".";
            {4'd6, 8'b110011}:  lookup = ",";
            {4'd6, 8'b001100}:  lookup = "?";
            {4'd6, 8'b011110}:  lookup = "'";
            {4'd6, 8'b101011}:  lookup = "!";
            {4'd5, 8'b10010}:   lookup = "/";
            {4'd5, 8'b10110}:   lookup = "(";
            {4'd6, 8'b101101}:  lookup = ")";
            {4'd5, 8'b01000}:   lookup = "&";
            {4'd6, 8'b111000}:  lookup = ":";
            {4'd6, 8'b101010}:  lookup = ";";
            {4'd5, 8'b10001}:   lookup = "=";
            {4'd5, 8'b01010}:   lookup = "+";
            {4'd6, 8'b100001}:  lookup = "-";
            {4'd6, 8'b001101}:  lookup = "_";
            {4'd6, 8'b010010}:  lookup = 8'h22;
            {4'd7, 8'b0001001}: lookup = "$";
            {4'd6, 8'b011010}:  lookup = "@";
`endif
            default:          lookup = UNKNOWN_CHAR;
        endcase
    endfunction

    assign char_code    = bad ? UNKNOWN_CHAR : lookup(sym_cnt, pattern);
    assign push_data    = state == EMIT_SPACE ? 8'h20 : char_code;
    assign accept       = sym_valid && sym_ready;
    assign gap          = accept && sym_code[1];
    assign char_valid   = fill_level != '0;
    assign char_data    = char_valid ? mem[rd_ptr] : 8'h00;
    assign pop          = char_valid && char_ready;
    assign room         = fill_level != FULL || pop;
    assign seq_overflow = accept && !sym_code[1] && sym_cnt == MAXC;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= COLLECT;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = clear ? COLLECT :
                    state == COLLECT ? (gap && sym_cnt != 0 ? EMIT_CHAR :
                                        gap && sym_code[0] && !last_was_space ? EMIT_SPACE : COLLECT) :
                    !room ? state :
                    state == EMIT_CHAR && pending_space ? EMIT_SPACE : COLLECT;
    end

    always_comb begin
        sym_ready = state == COLLECT && !clear;
        advance   = state != COLLECT && room && !clear;
        push      = advance && !flush;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sym_cnt        <= '0;
            pattern        <= '0;
            bad            <= 1'b0;
            pending_space  <= 1'b0;
            last_was_space <= 1'b1;
        end else begin
            if (clear) begin
                sym_cnt       <= '0;
                pattern       <= '0;
                bad           <= 1'b0;
                pending_space <= 1'b0;
            end else begin
                if (accept && !sym_code[1]) begin
                    if (sym_cnt == MAXC) bad <= 1'b1;
                    else begin
                        pattern <= pattern | (MAX_SYMS'(sym_code[0]) << sym_cnt);
                        sym_cnt <= sym_cnt + 4'd1;
                    end
                end
                if (gap && sym_code[0] && sym_cnt != 0) pending_space <= 1'b1;
                if (advance && state == EMIT_CHAR) begin
                    sym_cnt <= '0;
                    pattern <= '0;
                    bad     <= 1'b0;
                end
                if (advance && state == EMIT_SPACE) pending_space <= 1'b0;
            end
            if (flush)        last_was_space <= 1'b1;
            else if (advance) last_was_space <= state == EMIT_SPACE;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fill_level <= fill_level + (AW+1)'(push) - (AW+1)'(pop);
        end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_data;
endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb_morse_stream_decoder: directed scenarios plus a random symbol stream checked against a string-table model.
module tb_morse_stream_decoder;
    localparam int MAX = 6;

    logic       clk = 0, rst = 1;
    logic       sym_valid = 0, clear = 0, flush = 0, char_ready = 0;
    logic [1:0] sym_code = 0;
    logic       sym_ready, char_valid, seq_overflow;
    logic [7:0] char_data;
    logic [3:0] fill_level;

    int vec = 0, errs = 0, ovf_cnt = 0;
    logic [7:0] tbl [string];

    morse_stream_decoder #(.DEPTH(8), .MAX_SYMS(MAX), .UNKNOWN_CHAR(8'h3F)) dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_code(sym_code), .sym_ready(sym_ready),
        .clear(clear), .flush(flush), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .fill_level(fill_level), .seq_overflow(seq_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (seq_overflow === 1'b1) ovf_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; sym_valid = 0; clear = 0; flush = 0; char_ready = 0;
        @(negedge clk);
        rst = 0;
        ovf_cnt = 0;
    endtask

    task automatic send_sym(input logic [1:0] c);
        int n = 0;
        @(negedge clk);
        sym_valid = 1; sym_code = c;
        #1;
        while (!sym_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        vec++;
        if (sym_ready !== 1'b1) begin
            errs++;
            $display("FAIL send_sym timeout: sym_ready=%b required 1", sym_ready);
        end
        @(posedge clk); #1;
        sym_valid = 0;
    endtask

    task automatic pop_char(output logic [7:0] d, output logic v);
        int n = 0;
        @(negedge clk); #1;
        while (!char_valid && n < 100) begin
            @(negedge clk); #1; n++;
        end
        v = char_valid;
        d = char_data;
        char_ready = 1;
        @(posedge clk); #1;
        char_ready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        vec += 5;
        if (sym_ready !== 1'b1)     begin errs++; $display("FAIL reset sym_ready: got %b need 1", sym_ready); end
        if (char_valid !== 1'b0)    begin errs++; $display("FAIL reset char_valid: got %b need 0", char_valid); end
        if (char_data !== 8'h00)    begin errs++; $display("FAIL reset char_data: got %h need 00", char_data); end
        if (fill_level !== 4'd0)    begin errs++; $display("FAIL reset fill_level: got %0d need 0", fill_level); end
        if (seq_overflow !== 1'b0)  begin errs++; $display("FAIL reset seq_overflow: got %b need 0", seq_overflow); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_latency();
        do_reset();
        char_ready = 1;
        send_sym(2'b00); send_sym(2'b01);
        @(negedge clk);
        sym_valid = 1; sym_code = 2'b10;
        @(posedge clk); #1;
        sym_valid = 0;
        @(negedge clk); #1;
        vec++;
        if (char_valid !== 1'b0) begin errs++; $display("FAIL latency N+1 char_valid: got %b need 0", char_valid); end
        @(negedge clk); #1;
        vec += 2;
        if (char_valid !== 1'b1) begin errs++; $display("FAIL latency N+2 char_valid: got %b need 1", char_valid); end
        if (char_data !== 8'h41) begin errs++; $display("FAIL latency char_data: got %h need 41", char_data); end
        @(negedge clk); #1;
        vec++;
        if (fill_level !== 4'd0) begin errs++; $display("FAIL latency fill_level: got %0d need 0", fill_level); end
        char_ready = 0;
    endtask

    task automatic test_sos();
        logic [7:0] exp [4] = '{8'h53, 8'h4F, 8'h53, 8'h20};
        logic [7:0] d;
        logic v;
        do_reset();
        repeat (3) send_sym(2'b00); send_sym(2'b10);
        repeat (3) send_sym(2'b01); send_sym(2'b10);
        repeat (3) send_sym(2'b00); send_sym(2'b11);
        repeat (4) @(negedge clk);
        #1;
        vec++;
        if (fill_level !== 4'd4) begin errs++; $display("FAIL sos fill_level: got %0d need 4", fill_level); end
        for (int i = 0; i < 4; i++) begin
            pop_char(d, v);
            vec++;
            if (!v || d !== exp[i]) begin errs++; $display("FAIL sos char %0d: got %h (valid %b) need %h", i, d, v, exp[i]); end
        end
    endtask

    task automatic test_full();
        logic [7:0] d;
        logic v;
        do_reset();
        repeat (9) begin send_sym(2'b00); send_sym(2'b10); end
        repeat (3) @(negedge clk);
        #1;
        vec += 2;
        if (sym_ready !== 1'b0)  begin errs++; $display("FAIL full stall sym_ready: got %b need 0", sym_ready); end
        if (fill_level !== 4'd8) begin errs++; $display("FAIL full fill_level: got %0d need 8", fill_level); end
        @(negedge clk);
        char_ready = 1;
        #1;
        vec++;
        if (char_data !== 8'h45) begin errs++; $display("FAIL full head: got %h need 45", char_data); end
        @(posedge clk); #1;
        char_ready = 0;
        @(negedge clk); #1;
        vec += 2;
        if (fill_level !== 4'd8) begin errs++; $display("FAIL full push+pop fill_level: got %0d need 8", fill_level); end
        if (sym_ready !== 1'b1)  begin errs++; $display("FAIL full resume sym_ready: got %b need 1", sym_ready); end
        for (int i = 0; i < 8; i++) begin
            pop_char(d, v);
            vec++;
            if (!v || d !== 8'h45) begin errs++; $display("FAIL full drain %0d: got %h (valid %b) need 45", i, d, v); end
        end
        @(negedge clk); #1;
        vec++;
        if (fill_level !== 4'd0) begin errs++; $display("FAIL full empty fill_level: got %0d need 0", fill_level); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic v;
        do_reset();
        repeat (7) send_sym(2'b01);
        send_sym(2'b10);
        pop_char(d, v);
        vec += 2;
        if (!v || d !== 8'h3F) begin errs++; $display("FAIL overflow char: got %h (valid %b) need 3f", d, v); end
        if (ovf_cnt != 1)      begin errs++; $display("FAIL overflow pulses: got %0d need 1", ovf_cnt); end
    endtask

    task automatic test_clear();
        logic [7:0] d;
        logic v;
        do_reset();
        send_sym(2'b01); send_sym(2'b01);
        @(negedge clk);
        clear = 1; sym_valid = 1; sym_code = 2'b01;
        #1;
        vec++;
        if (sym_ready !== 1'b0) begin errs++; $display("FAIL clear sym_ready: got %b need 0", sym_ready); end
        @(posedge clk); #1;
        clear = 0; sym_valid = 0;
        send_sym(2'b00); send_sym(2'b10);
        pop_char(d, v);
        vec++;
        if (!v || d !== 8'h45) begin errs++; $display("FAIL clear char: got %h (valid %b) need 45", d, v); end
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if (char_valid !== 1'b0) begin errs++; $display("FAIL clear extra char: char_valid=%b need 0", char_valid); end
    endtask

    task automatic test_double_space();
        do_reset();
        send_sym(2'b01); send_sym(2'b11); send_sym(2'b11);
        repeat (4) @(negedge clk);
        #1;
        vec++;
        if (fill_level !== 4'd2) begin errs++; $display("FAIL double space fill_level: got %0d need 2", fill_level); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (3) begin send_sym(2'b00); send_sym(2'b10); end
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (fill_level !== 4'd3) begin errs++; $display("FAIL flush pre fill_level: got %0d need 3", fill_level); end
        @(negedge clk);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk); #1;
        vec += 2;
        if (char_valid !== 1'b0) begin errs++; $display("FAIL flush char_valid: got %b need 0", char_valid); end
        if (fill_level !== 4'd0) begin errs++; $display("FAIL flush fill_level: got %0d need 0", fill_level); end
        send_sym(2'b11);
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if (fill_level !== 4'd0) begin errs++; $display("FAIL flush word gap not ignored: fill %0d need 0", fill_level); end
    endtask

    task automatic test_reset_mid_space();
        do_reset();
        send_sym(2'b01); send_sym(2'b11);
        @(posedge clk); #1;
        vec++;
        if (sym_ready !== 1'b0) begin errs++; $display("FAIL midspace busy sym_ready: got %b need 0", sym_ready); end
        rst = 1;
        #1;
        vec += 4;
        if (sym_ready !== 1'b1)  begin errs++; $display("FAIL midspace sym_ready: got %b need 1", sym_ready); end
        if (char_valid !== 1'b0) begin errs++; $display("FAIL midspace char_valid: got %b need 0", char_valid); end
        if (char_data !== 8'h00) begin errs++; $display("FAIL midspace char_data: got %h need 00", char_data); end
        if (fill_level !== 4'd0) begin errs++; $display("FAIL midspace fill_level: got %0d need 0", fill_level); end
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if (fill_level !== 4'd0) begin errs++; $display("FAIL midspace late push: fill %0d need 0", fill_level); end
    endtask

    task automatic test_random();
        logic [1:0] syms [$];
        logic [7:0] exp [$];
        logic [7:0] got [$];
        string cur = "";
        bit bad = 0, lws = 1, done = 0;
        int exp_ovf = 0;
        do_reset();
        for (int l = 0; l < 60; l++) begin
            int len = $urandom_range(0, 7);
            for (int k = 0; k < len; k++) syms.push_back(2'($urandom_range(0, 1)));
            syms.push_back($urandom_range(0, 3) == 0 ? 2'b11 : 2'b10);
        end
        syms.push_back(2'b10);
        foreach (syms[i]) begin
            if (!syms[i][1]) begin
                if (cur.len() == MAX) begin bad = 1; exp_ovf++; end
                else cur = {cur, syms[i][0] ? "-" : "."};
            end else if (cur.len() > 0) begin
                exp.push_back(bad ? 8'h3F : tbl.exists(cur) ? tbl[cur] : 8'h3F);
                if (syms[i][0]) exp.push_back(8'h20);
                lws = syms[i][0];
                cur = ""; bad = 0;
            end else if (syms[i][0] && !lws) begin
                exp.push_back(8'h20);
                lws = 1;
            end
        end
        fork
            begin
                foreach (syms[i]) send_sym(syms[i]);
                done = 1;
            end
            begin
                int n = 0;
                @(negedge clk); #1;
                while (!(done && sym_ready && !char_valid) && n < 20000) begin
                    char_ready = 1'($urandom_range(0, 1));
                    if (char_valid && char_ready) got.push_back(char_data);
                    @(negedge clk); #1; n++;
                end
                char_ready = 0;
            end
        join
        vec += 2;
        if (got.size() != exp.size()) begin errs++; $display("FAIL random count: got %0d chars need %0d", got.size(), exp.size()); end
        if (ovf_cnt != exp_ovf)       begin errs++; $display("FAIL random overflow pulses: got %0d need %0d", ovf_cnt, exp_ovf); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vec++;
            if (got[i] !== exp[i]) begin errs++; $display("FAIL random char %0d: got %h need %h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                              "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                              "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                              "...--", "....-", ".....", "-....", "--...", "---..", "----."};
        string alph = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
        for (int i = 0; i < 36; i++) tbl[codes[i]] = alph[i];
        repeat (2) @(negedge clk);
        rst = 0;
        test_reset();
        test_latency();
        test_sos();
        test_full();
        test_overflow();
        test_clear();
        test_double_space();
        test_flush();
        test_reset_mid_space();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/morse_stream_decoder.md
Name: morse_stream_decoder

Overview:
Parametrised successor to the single-shot Morse translator path: accepts a stream of encoded Morse symbols (dot, dash, letter gap, word gap) and decodes each completed sequence to ASCII. Decoded characters are buffered in an internal FIFO and drained over a valid/ready handshake. It replaces the fixed three-character storage/translator chain, supporting unbounded text, configurable buffer depth and an explicit word separator. It sits after the Morse encoder and clock-enable logic, and feeds a display or UART sink.

Parameters:
DEPTH, 8, character FIFO entries; power of 2, >= 2.
MAX_SYMS, 6, maximum dots/dashes per sequence; range 5..8.
UNKNOWN_CHAR, 8'h3F, ASCII code emitted for any unrecognised or overlong sequence ('?').

Ports:
clk  in  1  single system clock, rising edge.
Reset  in  1  asynchronous active-high reset.
sym_valid  in  1  symbol offered.
sym_code  in  2  00 dot, 01 dash, 10 letter gap, 11 word gap.
sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
Clear  in  1  synchronous: discard partially collected sequence; FIFO untouched.
flush  in  1  synchronous: empty the FIFO; symbol collection untouched.
char_valid  out  1  FIFO non-empty.
char_data  out  8  ASCII at FIFO head; stable while char_valid && !char_ready.
char_ready  in  1  sink pops the head when char_valid && char_ready.
fill_level  out  $clog2(DEPTH)+1  FIFO occupancy.
seq_overflow  out  1  one-cycle pulse when a symbol arrives with MAX_SYMS symbols already collected.

Behaviour:
- Reset (async): state COLLECT, symbol count 0, pattern 0, FIFO empty, last_was_space=1. Outputs: sym_ready=1, char_valid=0, char_data=0, fill_level=0, seq_overflow=0.
- States: COLLECT, EMIT_CHAR, EMIT_SPACE.
- sym_ready=1 only in COLLECT.
- COLLECT, dot/dash accepted:
  - Shift the bit (dot=0, dash=1) into the pattern LSB-first in arrival order; count++.
  - If count==MAX_SYMS: do not store; set bad flag; pulse seq_overflow.
- COLLECT, letter gap accepted: count==0 -> ignored; else -> EMIT_CHAR.
- COLLECT, word gap accepted:
  - count>0 -> EMIT_CHAR, with pending_space set.
  - count==0 and !last_was_space -> EMIT_SPACE.
  - Otherwise ignored.
- EMIT_CHAR:
  - Lookup (count, pattern) against the ITU table: A-Z (uppercase) and 0-9. Anything else, or bad flag set -> UNKNOWN_CHAR.
  - Push when the FIFO has room, i.e. not full, or full with a pop in the same cycle. Otherwise stall.
  - On push: clear count, pattern and bad flag; last_was_space=0; go to EMIT_SPACE if pending_space, else COLLECT.
- EMIT_SPACE: push 8'h20 under the same room rule; last_was_space=1; clear pending_space; go to COLLECT.
- Latency: letter gap handshake in cycle N -> push at end of N+1 -> char_valid in N+2 (empty FIFO, no stall).
- FIFO: read/write pointers of $clog2(DEPTH) bits that wrap naturally; occupancy counter. Simultaneous push and pop leaves fill_level unchanged. A pop when empty is ignored.
- Clear: asserted in any state -> count, pattern, bad flag and pending_space cleared; next state COLLECT. Any symbol offered that cycle is not accepted (sym_ready forced 0 for that cycle). An in-progress push that same cycle is cancelled.
- flush: pointers and occupancy cleared; any push or pop that cycle is discarded; last_was_space=1.
- Clear and flush together: both take effect.
- Reset mid-emission: all state dropped, no partial push.

Optional Feature:
MORSE_PUNCT_EN
- Defined: lookup also decodes . , ? ' ! / ( ) & : ; = + - _ " $ @. These need 5-7 symbol patterns, limited to those that fit within MAX_SYMS.
- Undefined: these patterns yield UNKNOWN_CHAR; table logic is absent.

Test Plan:
- Dot, dash, letter gap with char_ready=1 -> char_data=8'h41 ('A'), char_valid in cycle N+2, fill_level returns to 0.
- "...", letter gap, "---", letter gap, "...", word gap, with char_ready=0 -> FIFO holds 53 4F 53 20; fill_level=4.
- DEPTH=8 and char_ready=0:
  - Feed 9 "E" letters (dot, letter gap) -> sym_ready stays 0 after the 9th gap while in EMIT_CHAR.
  - One pop -> 9th 'E' pushed next cycle; fill_level=8.
- Seven dashes with MAX_SYMS=6, then letter gap -> seq_overflow pulses once on the 7th dash; output 8'h3F.
- Dash, dash, Clear, dot, letter gap -> 'E' (8'h45) only.
- Two consecutive word gaps after 'T' -> exactly one 8'h20.
- flush with fill_level=3 -> char_valid=0 next cycle.
- Reset pulse mid-EMIT_SPACE -> all outputs return to reset values.
